sdram_pattern_tester: RTL

SDRAM_PATTERN_TESTER -- requirements
Module: sdram_pattern_tester

---
 rtl/sdram_pattern_tester.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_pattern_tester.sv
// rtl/sdram_pattern_tester.sv - SDRAM write-then-readback pattern tester
//
// Writes a pattern to every word address, reads it all back, and compares each word.
// Optional feature macro: SDRAM_TESTER_LFSR_EN (mode 2 = Galois LFSR pattern).
// Without the macro, mode 2 falls back to the address pattern of mode 0.
//
// Ports:
//   clk, reset            sole clock; synchronous active-high reset
//   start, mode[1:0]      begin-test pulse; pattern select, sampled at start
//   busy, done, pass      running; finished (sticky); finished with no errors
//   error_address/expected/actual   first mismatch capture
//   error_count[15:0]     saturating mismatch count
//   command[1:0]          0 idle, 1 write, 2 read (to memory controller)
//   data_address, data_write        word address and write data
//   data_read, data_read_valid      read data, one valid pulse per word
//   data_write_done                 one pulse per written word
module sdram_pattern_tester #(
  parameter int ADDR_WIDTH    = 22,
  parameter int DATA_WIDTH    = 16,
  parameter int BURST_LENGTH  = 1,
  parameter int STOP_ON_ERROR = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] error_address,
  output logic [DATA_WIDTH-1:0] error_expected,
  output logic [DATA_WIDTH-1:0] error_actual,
  output logic [15:0]           error_count,
  output logic [1:0]            command,
  output logic [ADDR_WIDTH-1:0] data_address,
  output logic [DATA_WIDTH-1:0] data_write,
  input  logic [DATA_WIDTH-1:0] data_read,
  input  logic                  data_read_valid,
  input  logic                  data_write_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    WR_GAP = 3'd2,
    READ   = 3'd3,
    RD_GAP = 3'd4,
    FINISH = 3'd5
  } state_t;

  localparam int                    EW        = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [EW-1:0]         DW_EXT    = EW'(DATA_WIDTH);
  localparam logic [3:0]            LAST_BEAT = 4'(BURST_LENGTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [DATA_WIDTH-1:0] ONE_HOT0  = DATA_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]              beat_q, beat_d;
  logic                    wrap_q, wrap_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
  logic [DATA_WIDTH-1:0]   err_exp_q, err_exp_d;
  logic [DATA_WIDTH-1:0]   err_act_q, err_act_d;

  logic [EW-1:0]           addr_ext;
  logic [EW-1:0]           bit_idx;
  logic [DATA_WIDTH-1:0]   expected;
  logic                    word_done;

`ifdef SDRAM_TESTER_LFSR_EN
  // Galois feedback masks: bit (tap-1) set for each tap of a maximal-length polynomial.
  function automatic logic [31:0] lfsr_taps(input int w);
    logic [31:0] t;
    case (w)
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0829;
      13:      t = 32'h0000_100D;
      14:      t = 32'h0000_2015;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_D008;
      17:      t = 32'h0001_2000;
      18:      t = 32'h0002_0400;
      19:      t = 32'h0004_0023;
      20:      t = 32'h0009_0000;
      21:      t = 32'h0014_0000;
      22:      t = 32'h0030_0000;
      23:      t = 32'h0042_0000;
      24:      t = 32'h00E1_0000;
      25:      t = 32'h0120_0000;
      26:      t = 32'h0200_0023;
      27:      t = 32'h0400_0013;
      28:      t = 32'h0900_0000;
      29:      t = 32'h1400_0000;
      30:      t = 32'h2000_0029;
      31:      t = 32'h4800_0000;
      default: t = 32'h8020_0003;
    endcase
    return t;
  endfunction

  localparam logic [31:0]           LFSR_TAPS = lfsr_taps(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] LFSR_MASK = LFSR_TAPS[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] LFSR_SEED = '1;

  logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0] lfsr_step;

  always_comb begin
    lfsr_step = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_step = lfsr_step ^ LFSR_MASK;
    end
  end
`endif

  // Expected word for the current address; mode 2 tracks the LFSR sequence, which
  // stays aligned with the address because both advance once per completed word.
  always_comb begin
    addr_ext = {{DATA_WIDTH{1'b0}}, addr_q};
    bit_idx  = addr_ext % DW_EXT;
    case (mode_q)
      2'd1:    expected = ONE_HOT0 << bit_idx;
      2'd3:    expected = ~addr_ext[DATA_WIDTH-1:0];
`ifdef SDRAM_TESTER_LFSR_EN
      2'd2:    expected = lfsr_q;
`endif
      default: expected = addr_ext[DATA_WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    wrap_d     = wrap_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    err_exp_d  = err_exp_q;
    err_act_d  = err_act_q;
    word_done  = 1'b0;
`ifdef SDRAM_TESTER_LFSR_EN
    lfsr_d     = lfsr_q;
`endif

    case (state_q)
      IDLE, FINISH: begin
        if (start) begin
          state_d    = WRITE;
          mode_d     = mode;
          addr_d     = '0;
          beat_d     = '0;
          wrap_d     = 1'b0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          err_cnt_d  = '0;
          err_addr_d = '0;
          err_exp_d  = '0;
          err_act_d  = '0;
`ifdef SDRAM_TESTER_LFSR_EN
          lfsr_d     = LFSR_SEED;
`endif
        end
      end
      WRITE: begin
        word_done = data_write_done;
      end
      WR_GAP: begin
        if (wrap_q) begin
          state_d = READ;
          wrap_d  = 1'b0;
`ifdef SDRAM_TESTER_LFSR_EN
          lfsr_d  = LFSR_SEED;
`endif
        end else begin
          state_d = WRITE;
        end
      end
      READ: begin
        word_done = data_read_valid;
        if (data_read_valid && (data_read != expected)) begin
          if (err_cnt_q == 16'd0) begin
            err_addr_d = addr_q;
            err_exp_d  = expected;
            err_act_d  = data_read;
          end
          if (err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
          end
        end
      end
      RD_GAP: begin
        if (wrap_q || ((STOP_ON_ERROR != 0) && (err_cnt_q != 16'd0))) begin
          state_d = FINISH;
          wrap_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_q == 16'd0);
        end else begin
          state_d = READ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A burst also closes early at the top address so the phase never runs past the wrap.
    if (word_done) begin
      addr_d = addr_q + 1'b1;
`ifdef SDRAM_TESTER_LFSR_EN
      lfsr_d = lfsr_step;
`endif
      if (addr_q == LAST_ADDR) begin
        wrap_d = 1'b1;
      end
      if ((beat_q == LAST_BEAT) || (addr_q == LAST_ADDR)) begin
        beat_d  = '0;
        state_d = (state_q == WRITE) ? WR_GAP : RD_GAP;
      end else begin
        beat_d = beat_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      addr_q     <= '0;
      beat_q     <= '0;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_act_q  <= '0;
`ifdef SDRAM_TESTER_LFSR_EN
      lfsr_q     <= '1;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      err_exp_q  <= err_exp_d;
      err_act_q  <= err_act_d;
`ifdef SDRAM_TESTER_LFSR_EN
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  always_comb begin
    command = 2'd0;
    if (state_q == WRITE) begin
      command = 2'd1;
    end else if (state_q == READ) begin
      command = 2'd2;
    end
  end

  assign busy           = (state_q == WRITE) || (state_q == WR_GAP) ||
                          (state_q == READ)  || (state_q == RD_GAP);
  assign done           = done_q;
  assign pass           = pass_q;
  assign error_count    = err_cnt_q;
  assign error_address  = err_addr_q;
  assign error_expected = err_exp_q;
  assign error_actual   = err_act_q;
  assign data_address   = addr_q;
  assign data_write     = (state_q == WRITE) ? expected : '0;

endmodule
